ppu_fetch_sequencer: RTL and testbench
======================================

// Module: ppu_fetch_sequencer
// PURPOSE
//  Parametrised PPU raster timing and memory-fetch sequencer. Replaces the fixed-width background-only FSM.
//  Generates dot/line counters from a configurable clock divider and the per-dot fetch phase for background
//  tiles, sprite slots and prefetch. Also generates scroll-register control strobes, VBLANK set/clear and odd-frame dot skip.
//  Sits between the PPU clock domain and the VRAM address mux / shift-register pipeline.
// PARAMETERS
//  CLKS_PER_DOT     4    clk cycles per PPU dot (1..16); 1 => dot_ce tied high
//  DOTS_PER_LINE    341  dots per line, dot range 0..DOTS_PER_LINE-1 (<=512)
//  LINES_PER_FRAME  262  lines per frame; pre-render line PRE = LINES_PER_FRAME-1
//  VIS_LINES        240  visible lines 0..VIS_LINES-1
//  VBLANK_LINE      241  line whose dot 1 raises vblank_set
//  ODD_SKIP_EN      1    1: skip last dot of PRE on odd frames when rendering
// PORTS
//  clk           in   1  PPU master clock
//  rst           in   1  synchronous, active-high reset
//  rendering_en  in   1  BG|sprite enable from PPUMASK (sampled each dot_ce)
//  dot_ce        out  1  one-clk pulse on last clk of each dot; counters advance on it
//  dot           out  9  current dot
//  line          out  9  current line
//  fetch_phase   out  3  0 IDLE,1 NT,2 AT,3 PT_LO,4 PT_HI,5 SPR_NT,6 SPR_LO,7 SPR_HI
//  fetch_strobe  out  1  data-capture pulse on 2nd dot of each 2-dot fetch slot
//  hscroll_inc   out  1  coarse-X increment pulse
//  vscroll_inc   out  1  Y increment pulse
//  hcopy         out  1  t->v horizontal copy pulse
//  vcopy         out  1  t->v vertical copy pulse
//  vblank_set    out  1  set PPUSTATUS.7 / NMI source
//  vblank_clr    out  1  clear VBLANK, sprite-0, overflow
//  odd_frame     out  1  frame parity, toggles at frame wrap
//  frame_start   out  1  pulse when line 0 dot 0 begins
// BEHAVIOUR
//  Reset: div=0, dot=0, line=PRE, odd_frame=0, fetch_phase=IDLE; all pulses 0. dot_ce=0 (CLKS_PER_DOT>1).
//  Reset mid-frame has the same result on the next clk; no partial pulse is emitted.
//  Divider: counts 0..CLKS_PER_DOT-1; dot_ce=1 when div==CLKS_PER_DOT-1.
//  Dot wrap: DOTS_PER_LINE-1 -> 0, line+1. Line wrap: PRE -> 0, odd_frame toggles, frame_start pulses.
//  Odd skip: at line PRE, dot DOTS_PER_LINE-2, dot_ce, odd_frame=1, rendering_en=1, ODD_SKIP_EN=1:
//   jump directly to line 0 dot 0 (one dot shorter frame). No skip if any of these conditions is false.
//  All pulse outputs are high only in the clk where dot_ce=1 and dot/line match the event. Fetch lines are 0..VIS_LINES-1 and PRE.
//  fetch_phase is a level for the whole dot. It is IDLE off fetch lines or when rendering_en=0.
//  Fetch map, with g=(dot-1)%8:
//   dot 0: IDLE.
//   dots 1-256 and 321-336: g0-1 NT, g2-3 AT, g4-5 PT_LO, g6-7 PT_HI.
//   dots 257-320: g0-3 SPR_NT, g4-5 SPR_LO, g6-7 SPR_HI.
//   dots 337-340: NT.
//  fetch_strobe: on odd g (dots 2,4,6,8,...) in every non-IDLE phase, and on dots 338 and 340.
//  hscroll_inc at dots 8,16,..,256,328,336; vscroll_inc at dot 256; hcopy at dot 257.
//  vcopy on PRE, dots 280-304 inclusive.
//  The scroll pulses above require a fetch line and rendering_en=1.
//  vblank_set at line VBLANK_LINE dot 1; vblank_clr at line PRE dot 1. Both fire regardless of rendering_en.
//  rendering_en change mid-line takes effect on the next dot. A rising edge mid-line does not retro-issue missed pulses.
//  Widths: dot/line compare at 9 bits; parameters outside the stated ranges are unsupported.
// TESTING
//  Reset: assert rst 3 clk -> dot=0, line=261, fetch_phase=0, odd_frame=0, no pulses.
//  Line 0, rendering_en=1: dots 1..8 -> phase 1,1,2,2,3,3,4,4; strobe at dots 2,4,6,8; hscroll_inc at dot 8.
//  Frame length, rendering on: even frame = 341*262 dots; odd frame = 89341 dots, line 261 ends at dot 339.
//  Rendering off: no odd skip (89342 dots each frame), phase stays 0, no scroll pulses.
//   vblank_set at (241,1) and vblank_clr at (261,1) still present.
//  PRE line: vcopy pulses 25 dots (280-304); hcopy at 257; SPR phases 257-320; vscroll_inc at 256.
//  CLKS_PER_DOT=1 and =4 builds: dot_ce period 1/4 clk; rst at line 100 dot 200 -> restart at (261,0).

Source files
------------

// File: rtl/ppu_fetch_sequencer.sv
// PPU raster timing: dot/line counters driven by a clock divider, plus the per-dot VRAM
// fetch phase, scroll-register strobes, VBLANK set/clear and the odd-frame dot skip.
module ppu_fetch_sequencer #(
  parameter int CLKS_PER_DOT    = 4,
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VIS_LINES       = 240,
  parameter int VBLANK_LINE     = 241,
  parameter int ODD_SKIP_EN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rendering_en,
  output logic       dot_ce,
  output logic [8:0] dot,
  output logic [8:0] line,
  output logic [2:0] fetch_phase,
  output logic       fetch_strobe,
  output logic       hscroll_inc,
  output logic       vscroll_inc,
  output logic       hcopy,
  output logic       vcopy,
  output logic       vblank_set,
  output logic       vblank_clr,
  output logic       odd_frame,
  output logic       frame_start
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] PRE_LINE  = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VIS_END   = 9'(VIS_LINES);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_NT     = 3'd1;
  localparam logic [2:0] PH_AT     = 3'd2;
  localparam logic [2:0] PH_PT_LO  = 3'd3;
  localparam logic [2:0] PH_PT_HI  = 3'd4;
  localparam logic [2:0] PH_SPR_NT = 3'd5;
  localparam logic [2:0] PH_SPR_LO = 3'd6;
  localparam logic [2:0] PH_SPR_HI = 3'd7;

  logic [8:0] dot_reg, dot_next;
  logic [8:0] line_reg, line_next;
  logic       odd_reg, odd_next;
  logic       rend_reg;
  logic       skip;
  logic       tick;
  logic       fetch_line;
  logic       render_line;
  logic       bg_span;
  logic [2:0] g;
  logic [7:0] hit;
  logic [7:0] pulse;

  // Divider: a single-clock dot needs no counter, dot_ce is simply always set.
  generate
    if (CLKS_PER_DOT == 1) begin : g_div1
      assign dot_ce = 1'b1;
    end else begin : g_div
      localparam logic [3:0] DIV_LAST = 4'(CLKS_PER_DOT - 1);
      logic [3:0] div_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          div_reg <= 4'd0;
        end else if (div_reg == DIV_LAST) begin
          div_reg <= 4'd0;
        end else begin
          div_reg <= div_reg + 4'd1;
        end
      end

      assign dot_ce = ~rst & (div_reg == DIV_LAST);
    end
  endgenerate

  // Pulses are qualified by reset too so a reset clk never leaks a partial event.
  assign tick = dot_ce & ~rst;

  always_comb begin
    dot_next  = dot_reg + 9'd1;
    line_next = line_reg;
    odd_next  = odd_reg;
    skip      = (ODD_SKIP_EN != 0) && (line_reg == PRE_LINE) && (dot_reg == SKIP_DOT)
                && odd_reg && rendering_en;
    if (skip || ((dot_reg == LAST_DOT) && (line_reg == PRE_LINE))) begin
      dot_next  = 9'd0;
      line_next = 9'd0;
      odd_next  = ~odd_reg;
    end else if (dot_reg == LAST_DOT) begin
      dot_next  = 9'd0;
      line_next = line_reg + 9'd1;
    end
  end

  // rend_reg holds the rendering enable that applies to the dot now in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      dot_reg  <= 9'd0;
      line_reg <= PRE_LINE;
      odd_reg  <= 1'b0;
      rend_reg <= 1'b0;
    end else if (dot_ce) begin
      dot_reg  <= dot_next;
      line_reg <= line_next;
      odd_reg  <= odd_next;
      rend_reg <= rendering_en;
    end
  end

  assign fetch_line  = (line_reg < VIS_END) || (line_reg == PRE_LINE);
  assign render_line = rend_reg && fetch_line;
  assign bg_span     = ((dot_reg >= 9'd1) && (dot_reg <= 9'd256))
                    || ((dot_reg >= 9'd321) && (dot_reg <= 9'd336));
  assign g           = dot_reg[2:0] - 3'd1;

  always_comb begin
    fetch_phase = PH_IDLE;
    if (render_line && (dot_reg != 9'd0)) begin
      if (bg_span) begin
        case (g[2:1])
          2'd0:    fetch_phase = PH_NT;
          2'd1:    fetch_phase = PH_AT;
          2'd2:    fetch_phase = PH_PT_LO;
          default: fetch_phase = PH_PT_HI;
        endcase
      end else if ((dot_reg >= 9'd257) && (dot_reg <= 9'd320)) begin
        if (!g[2]) begin
          fetch_phase = PH_SPR_NT;
        end else if (!g[1]) begin
          fetch_phase = PH_SPR_LO;
        end else begin
          fetch_phase = PH_SPR_HI;
        end
      end else if ((dot_reg >= 9'd337) && (dot_reg <= 9'd340)) begin
        fetch_phase = PH_NT;
      end
    end
  end

  // Event matches for the current dot; each becomes a pulse only on the dot's final clk.
  always_comb begin
    hit    = 8'd0;
    hit[0] = (fetch_phase != PH_IDLE) && !dot_reg[0];
    if (render_line) begin
      hit[1] = bg_span && (dot_reg[2:0] == 3'd0);
      hit[2] = (dot_reg == 9'd256);
      hit[3] = (dot_reg == 9'd257);
      hit[4] = (line_reg == PRE_LINE) && (dot_reg >= 9'd280) && (dot_reg <= 9'd304);
    end
    hit[5] = (line_reg == VBL_LINE) && (dot_reg == 9'd1);
    hit[6] = (line_reg == PRE_LINE) && (dot_reg == 9'd1);
    hit[7] = (line_reg == 9'd0) && (dot_reg == 9'd0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pulse
      assign pulse[gi] = tick & hit[gi];
    end
  endgenerate

  assign fetch_strobe = pulse[0];
  assign hscroll_inc  = pulse[1];
  assign vscroll_inc  = pulse[2];
  assign hcopy        = pulse[3];
  assign vcopy        = pulse[4];
  assign vblank_set   = pulse[5];
  assign vblank_clr   = pulse[6];
  assign frame_start  = pulse[7];

  assign dot       = dot_reg;
  assign line      = line_reg;
  assign odd_frame = odd_reg;

endmodule

// File: tb/tb_ppu_fetch_sequencer.sv
// Scoreboard bench for ppu_fetch_sequencer on a short 8-line frame so several whole frames fit.
module tb_ppu_fetch_sequencer;

  localparam int CPD = 4;
  localparam int DPL = 341;
  localparam int LPF = 8;
  localparam int VIS = 4;
  localparam int VBL = 5;
  localparam int PRE = LPF - 1;

  localparam int HS = 1, VS = 2, HC = 4, VC = 8, VSET = 16, VCLR = 32, FS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rendering_en;
  logic       dot_ce;
  logic [8:0] dot;
  logic [8:0] line;
  logic [2:0] fetch_phase;
  logic       fetch_strobe, hscroll_inc, vscroll_inc, hcopy, vcopy;
  logic       vblank_set, vblank_clr, odd_frame, frame_start;

  always #5 clk = ~clk;

  ppu_fetch_sequencer #(
    .CLKS_PER_DOT(CPD), .DOTS_PER_LINE(DPL), .LINES_PER_FRAME(LPF),
    .VIS_LINES(VIS), .VBLANK_LINE(VBL), .ODD_SKIP_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .rendering_en(rendering_en), .dot_ce(dot_ce),
    .dot(dot), .line(line), .fetch_phase(fetch_phase), .fetch_strobe(fetch_strobe),
    .hscroll_inc(hscroll_inc), .vscroll_inc(vscroll_inc), .hcopy(hcopy), .vcopy(vcopy),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .odd_frame(odd_frame),
    .frame_start(frame_start)
  );

  typedef struct {int ln; int dt; int vec; int odd;} ev_t;
  typedef struct {int ln; int dt; int ph; int stb;} ph_t;

  ev_t evq[$];
  ph_t phq[$];
  int  lenq[$];
  int  checks = 0;
  int  errors = 0;
  int  fs_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int ln, input int dt, input int vec, input int odd);
    evq.push_back('{ln, dt, vec, odd});
  endtask

  task automatic push_ph(input int ln, input int dt, input int ph, input int stb);
    phq.push_back('{ln, dt, ph, stb});
  endtask

  // Scroll/vblank events of one rendered fetch line, in dot order.
  task automatic push_fetch_line(input int ln, input int odd);
    if (ln == PRE) push_ev(ln, 1, VCLR, odd);
    for (int d = 8; d <= 248; d += 8) push_ev(ln, d, HS, odd);
    push_ev(ln, 256, HS | VS, odd);
    push_ev(ln, 257, HC, odd);
    if (ln == PRE) for (int d = 280; d <= 304; d++) push_ev(ln, d, VC, odd);
    push_ev(ln, 328, HS, odd);
    push_ev(ln, 336, HS, odd);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_dot"}, int'(dot), 0);
    chk({tag, "_line"}, int'(line), PRE);
    chk({tag, "_phase"}, int'(fetch_phase), 0);
    chk({tag, "_odd"}, int'(odd_frame), 0);
    chk({tag, "_dot_ce"}, int'(dot_ce), 0);
    chk({tag, "_pulses"}, int'({fetch_strobe, hscroll_inc, vscroll_inc, hcopy, vcopy,
                                vblank_set, vblank_clr, frame_start}), 0);
  endtask

  task automatic wait_for(input int fs, input int ln, input int dt, input int budget);
    int n;
    n = 0;
    while (!(fs_seen == fs && int'(line) == ln && int'(dot) == dt) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_f%0d_%0d_%0d", fs, ln, dt), int'(n < budget), 1);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  int  mon_vec;
  int  fcnt = 0;
  bit  fs_started = 1'b0;
  int  gap = 0;
  bit  gap_valid = 1'b0;
  ev_t e;
  ph_t p;

  always @(negedge clk) begin
    mon_vec = int'({frame_start, vblank_clr, vblank_set, vcopy, hcopy, vscroll_inc, hscroll_inc});
    if (mon_vec != 0) begin
      chk($sformatf("pulse_needs_dot_ce_%0d_%0d", line, dot), int'(dot_ce), 1);
      if (evq.size() == 0) begin
        chk($sformatf("unexpected_event_%0d_%0d", line, dot), mon_vec, 0);
      end else begin
        e = evq.pop_front();
        chk($sformatf("ev_%0d_%0d_line", e.ln, e.dt), int'(line), e.ln);
        chk($sformatf("ev_%0d_%0d_dot", e.ln, e.dt), int'(dot), e.dt);
        chk($sformatf("ev_%0d_%0d_vec", e.ln, e.dt), mon_vec, e.vec);
        chk($sformatf("ev_%0d_%0d_odd", e.ln, e.dt), int'(odd_frame), e.odd);
      end
    end
    if (dot_ce && phq.size() > 0 && int'(line) == phq[0].ln && int'(dot) == phq[0].dt) begin
      p = phq.pop_front();
      chk($sformatf("phase_%0d_%0d", p.ln, p.dt), int'(fetch_phase), p.ph);
      chk($sformatf("strobe_%0d_%0d", p.ln, p.dt), int'(fetch_strobe), p.stb);
    end
    if (rst) begin
      fs_started = 1'b0;
      gap_valid  = 1'b0;
    end else if (dot_ce) begin
      if (gap_valid) chk("dot_ce_period", gap, CPD);
      gap_valid = 1'b1;
      gap = 1;
      if (frame_start) begin
        fs_seen++;
        if (fs_started) begin
          if (lenq.size() > 0) chk("frame_len", fcnt + 1, lenq.pop_front());
          else chk("frame_len_extra", fcnt + 1, 0);
        end
        fcnt = 0;
        fs_started = 1'b1;
      end else begin
        fcnt++;
      end
    end else begin
      gap++;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rendering_en = 1'b1;

    // Rendering-on stretch: partial PRE after reset, odd frame A (skipped dot), even frame B.
    push_fetch_line(PRE, 0);
    push_ev(0, 0, FS, 1);
    for (int l = 0; l < VIS; l++) push_fetch_line(l, 1);
    push_ev(VBL, 1, VSET, 1);
    push_fetch_line(PRE, 1);
    push_ev(0, 0, FS, 0);
    for (int l = 0; l < VIS; l++) push_fetch_line(l, 0);
    push_ev(VBL, 1, VSET, 0);

    push_ph(PRE, 255, 4, 0); push_ph(PRE, 256, 4, 1); push_ph(PRE, 257, 5, 0);
    push_ph(PRE, 258, 5, 1); push_ph(PRE, 261, 6, 0); push_ph(PRE, 263, 7, 0);
    push_ph(PRE, 264, 7, 1); push_ph(PRE, 320, 7, 1); push_ph(PRE, 321, 1, 0);
    push_ph(PRE, 337, 1, 0); push_ph(PRE, 338, 1, 1); push_ph(PRE, 340, 1, 1);
    push_ph(0, 0, 0, 0); push_ph(0, 1, 1, 0); push_ph(0, 2, 1, 1); push_ph(0, 3, 2, 0);
    push_ph(0, 4, 2, 1); push_ph(0, 5, 3, 0); push_ph(0, 6, 3, 1); push_ph(0, 7, 4, 0);
    push_ph(0, 8, 4, 1); push_ph(0, 9, 1, 0);
    push_ph(VIS, 100, 0, 0);
    push_ph(PRE, 3, 2, 0);

    lenq.push_back(DPL * LPF - 1);
    lenq.push_back(DPL * LPF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Drop rendering on frame B's vblank line: no more scroll pulses, no odd skip.
    wait_for(2, VBL, 10, 60000);
    rendering_en = 1'b0;
    push_ev(PRE, 1, VCLR, 0);
    push_ev(0, 0, FS, 1);
    push_ev(VBL, 1, VSET, 1);
    push_ev(PRE, 1, VCLR, 1);
    push_ev(0, 0, FS, 0);
    push_ph(PRE, 258, 0, 0);
    push_ph(0, 8, 0, 0);
    push_ph(PRE, 258, 0, 0);
    lenq.push_back(DPL * LPF);

    // Mid-frame reset in frame D.
    wait_for(4, 3, 200, 60000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("mid_reset");
    rst = 1'b0;
    repeat (CPD) @(posedge clk);
    @(negedge clk);
    chk("restart_dot", int'(dot), 1);
    chk("restart_line", int'(line), PRE);

    chk("evq_drained", evq.size(), 0);
    chk("phq_drained", phq.size(), 0);
    chk("lenq_drained", lenq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
